// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out word transmitter
//
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and shifts it
// out one bit per enabled clock, with a frame-valid flag and a last-bit marker.
// Back-to-back words stream with no gap when the next word is offered while the
// last bit of the current word is being shifted out.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-low reset
//   load_valid  in   producer offers a word on load_data
//   load_ready  out  serializer accepts a word this cycle (combinational)
//   load_data   in   WIDTH-bit word, sampled only on acceptance
//   ser_en      in   shift enable; 0 freezes the serial side
//   ser_out     out  current serial bit (registered)
//   ser_valid   out  ser_out carries a valid bit (registered)
//   ser_last    out  ser_out is the final bit of the word (registered)
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             accept;

  // A new word can be taken when idle, or on the enabled cycle that retires
  // the last bit of the current word (gapless streaming).
  assign load_ready = rst & ((state_q == IDLE) |
                             ((state_q == SHIFT) & ser_last_q & ser_en));
  assign accept     = load_valid & load_ready;

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // The shift register keeps the word aligned so that the bit on ser_out is
  // always at the "send" end (bit WIDTH-1 for MSB-first, bit 0 otherwise);
  // the next bit to present is read from its neighbour before shifting.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;

    unique case (state_q)
      IDLE: begin
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        count_d     = '0;
        if (accept) begin
          state_d     = SHIFT;
          shreg_d     = load_data;
          count_d     = '0;
          ser_out_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
          ser_valid_d = 1'b1;
        end
      end

      SHIFT: begin
        if (ser_en) begin
          if (!ser_last_q) begin
            count_d    = count_q + CNT_W'(1);
            ser_last_d = (count_d == LAST_CNT);
            if (MSB_FIRST) begin
              shreg_d   = shreg_q << 1;
              ser_out_d = shreg_q[WIDTH-2];
            end else begin
              shreg_d   = shreg_q >> 1;
              ser_out_d = shreg_q[1];
            end
          end else if (load_valid) begin
            // Reload: first bit of the next word follows immediately.
            shreg_d     = load_data;
            count_d     = '0;
            ser_out_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b0;
          end else begin
            state_d     = IDLE;
            count_d     = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (WIDTH=8, both bit orders)
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_en;

  logic ready_m, out_m, valid_m, last_m;
  logic ready_l, out_l, valid_l, last_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .ser_en(ser_en), .ser_out(out_m),
    .ser_valid(valid_m), .ser_last(last_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .ser_en(ser_en), .ser_out(out_l),
    .ser_valid(valid_l), .ser_last(last_l)
  );

  // Reference: the i-th transmitted bit of word w, by bit order.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    return msb ? w[7 - i] : w[i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word from idle, optionally stalling ser_en for stall_len cycles
  // while bit stall_at is presented; checks both bit orders bit by bit.
  task automatic send_check(input logic [7:0] w, input int stall_at,
                            input int stall_len, input string name);
    logic [1:0] exp_out;
    load_valid = 1'b1;
    load_data  = w;
    ser_en     = 1'($urandom);
    #1;
    tests++;
    if ({ready_m, ready_l} !== 2'b11) begin
      fails++;
      $display("FAIL %s idle_ready got=%b exp=11", name, {ready_m, ready_l});
    end
    step();
    load_valid = 1'b0;
    load_data  = 8'($urandom);
    ser_en     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_out = {exp_bit(w, i, 1'b1), exp_bit(w, i, 1'b0)};
      tests++;
      if ({valid_m, valid_l, out_m, out_l, last_m, last_l} !==
          {2'b11, exp_out, (i == 7), (i == 7)}) begin
        fails++;
        $display("FAIL %s bit%0d got v=%b o=%b l=%b exp v=11 o=%b l=%b",
                 name, i, {valid_m, valid_l}, {out_m, out_l},
                 {last_m, last_l}, exp_out, {2{i == 7}});
      end
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          ser_en = 1'b0;
          #1;
          tests++;
          if ({ready_m, ready_l} !== 2'b00) begin
            fails++;
            $display("FAIL %s stall_ready got=%b exp=00", name, {ready_m, ready_l});
          end
          step();
          tests++;
          if ({valid_m, valid_l, out_m, out_l, last_m, last_l} !==
              {2'b11, exp_out, (i == 7), (i == 7)}) begin
            fails++;
            $display("FAIL %s stall_hold bit%0d got o=%b l=%b exp o=%b l=%b",
                     name, i, {out_m, out_l}, {last_m, last_l}, exp_out, {2{i == 7}});
          end
        end
      end
      ser_en = 1'b1;
      #1;
      tests++;
      if ({ready_m, ready_l} !== {2{i == 7}}) begin
        fails++;
        $display("FAIL %s shift_ready bit%0d got=%b exp=%b", name, i,
                 {ready_m, ready_l}, {2{i == 7}});
      end
      step();
    end
    tests++;
    if ({valid_m, valid_l, out_m, out_l, last_m, last_l} !== 6'b0) begin
      fails++;
      $display("FAIL %s end_idle got v=%b o=%b l=%b exp all 0", name,
               {valid_m, valid_l}, {out_m, out_l}, {last_m, last_l});
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    ser_en     = 1'b1;
    step();
    step();
    tests++;
    if ({valid_m, valid_l, out_m, out_l, last_m, last_l} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b o=%b l=%b exp all 0",
               {valid_m, valid_l}, {out_m, out_l}, {last_m, last_l});
    end
    tests++;
    if ({ready_m, ready_l} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=00", {ready_m, ready_l});
    end
    load_valid = 1'b0;
    rst        = 1'b1;
    #1;
    tests++;
    if ({ready_m, ready_l} !== 2'b11) begin
      fails++;
      $display("FAIL release_ready got=%b exp=11", {ready_m, ready_l});
    end
    step();
    tests++;
    if ({valid_m, valid_l} !== 2'b00) begin
      fails++;
      $display("FAIL reset_no_accept got=%b exp=00", {valid_m, valid_l});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    int ready_hi;
    words[0]   = 8'hB2;
    words[1]   = 8'h4E;
    ready_hi   = 0;
    load_valid = 1'b1;
    load_data  = words[0];
    ser_en     = 1'b1;
    step();
    load_data = words[1];
    for (int k = 0; k < 16; k++) begin
      tests++;
      if ({valid_m, valid_l, out_m, out_l} !==
          {2'b11, exp_bit(words[k / 8], k % 8, 1'b1), exp_bit(words[k / 8], k % 8, 1'b0)}) begin
        fails++;
        $display("FAIL b2b bit%0d got v=%b o=%b exp v=11 o=%b", k,
                 {valid_m, valid_l}, {out_m, out_l},
                 {exp_bit(words[k / 8], k % 8, 1'b1), exp_bit(words[k / 8], k % 8, 1'b0)});
      end
      #1;
      if (k < 8 && ready_m === 1'b1 && ready_l === 1'b1) ready_hi++;
      step();
      if (k == 7) load_valid = 1'b0;
    end
    tests++;
    if ({valid_m, valid_l} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_end_valid got=%b exp=00", {valid_m, valid_l});
    end
    tests++;
    if (ready_hi !== 1) begin
      fails++;
      $display("FAIL b2b_ready_count got=%0d exp=1", ready_hi);
    end
  endtask

  task automatic test_reset_mid_word();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    ser_en     = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    tests++;
    if ({valid_m, valid_l, out_m, out_l, last_m, last_l} !== 6'b0) begin
      fails++;
      $display("FAIL midreset_outputs got v=%b o=%b l=%b exp all 0",
               {valid_m, valid_l}, {out_m, out_l}, {last_m, last_l});
    end
    tests++;
    if ({ready_m, ready_l} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_ready got=%b exp=00", {ready_m, ready_l});
    end
    rst = 1'b1;
    send_check(8'h01, -1, 0, "after_midreset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      send_check(8'($urandom), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    send_check(8'hB2, -1, 0, "word_b2");
    test_back_to_back();
    send_check(8'hB2, 2, 3, "stall");
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
